// File: rtl/config_chain_loader.sv
// Configuration chain loader: bitstream words are serialized into a shadow chain and committed to mem_out/mem_outb in one cycle.
// Optional even-parity checking of each accepted word is enabled by defining CONFIG_PARITY_EN.
`timescale 1ns/1ps
module config_chain_loader #(
  parameter int NUM_BITS = 32,
  parameter int WORD_W   = 8
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic                start,
  input  logic [WORD_W-1:0]   cfg_data,
  input  logic                cfg_valid,
`ifdef CONFIG_PARITY_EN
  input  logic                cfg_parity,
`endif
  output logic                cfg_ready,
  output logic [NUM_BITS-1:0] mem_out,
  output logic [NUM_BITS-1:0] mem_outb,
  output logic                ccff_tail,
  output logic                config_done
`ifdef CONFIG_PARITY_EN
  ,
  output logic                err_parity
`endif
);

  localparam int CW = $clog2(NUM_BITS + 1);
  localparam int SW = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, DONE} state_t;

  state_t              state, state_nxt;
  logic [NUM_BITS-1:0] shadow, shadow_shl;
  logic [WORD_W-1:0]   ser_word;
  logic [SW-1:0]       ser_cnt, load_cnt;
  logic [CW-1:0]       acc_cnt, bit_cnt;
  logic [31:0]         remain;
  logic                shift_en, accept, last_shift, start_load, commit_en;

  assign shift_en   = (ser_cnt != '0);
  assign accept     = cfg_valid && cfg_ready;
  assign last_shift = shift_en && (bit_cnt == CW'(NUM_BITS - 1));
  assign start_load = start && ((state == IDLE) || (state == DONE));
  assign ccff_tail  = shadow[NUM_BITS-1];

  // Only the bits still missing from the chain are loaded; the rest of a final word is dropped.
  assign remain   = 32'(NUM_BITS) - 32'(acc_cnt);
  assign load_cnt = (remain < 32'(WORD_W)) ? SW'(remain) : SW'(WORD_W);

  generate
    if (NUM_BITS > 1) begin : g_shl
      assign shadow_shl = {shadow[NUM_BITS-2:0], ser_word[0]};
    end else begin : g_shl1
      assign shadow_shl = ser_word[0];
    end
  endgenerate

`ifdef CONFIG_PARITY_EN
  assign commit_en = (state == COMMIT) && !err_parity;
`else
  assign commit_en = (state == COMMIT);
`endif

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start) state_nxt = SHIFT;
      SHIFT:      if (last_shift) state_nxt = COMMIT;
      COMMIT:     state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready   = (state == SHIFT) && ((ser_cnt == '0) || (ser_cnt == SW'(1)))
                  && (acc_cnt < CW'(NUM_BITS));
    config_done = (state == DONE);
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      shadow   <= '0;
      ser_word <= '0;
      ser_cnt  <= '0;
      acc_cnt  <= '0;
      bit_cnt  <= '0;
      mem_out  <= '0;
      mem_outb <= '1;
`ifdef CONFIG_PARITY_EN
      err_parity <= 1'b0;
`endif
    end else begin
      if (start_load) begin
        acc_cnt <= '0;
        bit_cnt <= '0;
        ser_cnt <= '0;
`ifdef CONFIG_PARITY_EN
        err_parity <= 1'b0;
`endif
      end
      if (shift_en) begin
        shadow   <= shadow_shl;
        ser_word <= ser_word >> 1;
        ser_cnt  <= ser_cnt - SW'(1);
        bit_cnt  <= bit_cnt + CW'(1);
      end
      // A new word may load on the same edge the previous word's last bit shifts.
      if (accept) begin
        ser_word <= cfg_data;
        ser_cnt  <= load_cnt;
        acc_cnt  <= acc_cnt + CW'(load_cnt);
`ifdef CONFIG_PARITY_EN
        if (^{cfg_data, cfg_parity}) err_parity <= 1'b1;
`endif
      end
      if (commit_en) begin
        mem_out  <= shadow;
        mem_outb <= ~shadow;
      end
    end
  end

endmodule

// File: tb/tb_config_chain_loader.sv
// Scoreboard bench for config_chain_loader: the driver pushes expected commit results, a negedge monitor pops and checks them.
`timescale 1ns/1ps
module tb_config_chain_loader;
  localparam int NB = 12;
  localparam int WW = 8;
  localparam int NW = (NB + WW - 1) / WW;

  logic          prog_clk = 1'b0;
  logic          pReset = 1'b1;
  logic          start = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [WW-1:0] cfg_data = '0;
  logic          cfg_ready, ccff_tail, config_done;
  logic [NB-1:0] mem_out, mem_outb;
`ifdef CONFIG_PARITY_EN
  logic          cfg_parity = 1'b0;
  logic          err_parity;
`endif

  config_chain_loader #(.NUM_BITS(NB), .WORD_W(WW)) dut (
    .prog_clk(prog_clk), .pReset(pReset), .start(start),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid),
`ifdef CONFIG_PARITY_EN
    .cfg_parity(cfg_parity),
`endif
    .cfg_ready(cfg_ready), .mem_out(mem_out), .mem_outb(mem_outb),
    .ccff_tail(ccff_tail), .config_done(config_done)
`ifdef CONFIG_PARITY_EN
    , .err_parity(err_parity)
`endif
  );

  always #5 prog_clk = ~prog_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge prog_clk) cyc <= cyc + 1;

  typedef struct {
    logic [NB-1:0] mem;
    logic          tail;
    bit            err;
    int            done_cyc;
  } exp_t;

  exp_t          sbq[$];
  logic [NB-1:0] shown = '0;
  logic [NB-1:0] model_mem = '0;
  logic [NB-1:0] model_shadow = '0;
  logic [NB-1:0] tail_old = '0;
  logic [WW-1:0] wq[NW];
  int            gq[NW];
  bit            bq[NW];
  event          acc0_ev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected chain contents: stream bit k ends up at position NB-1-k.
  function automatic logic [NB-1:0] stream_val();
    logic [NB-1:0] v = '0;
    int k = 0;
    for (int i = 0; i < NW; i++)
      for (int b = 0; b < WW; b++)
        if (k < NB) begin
          v[NB-1-k] = wq[i][b];
          k++;
        end
    return v;
  endfunction

  initial begin : monitor
    exp_t          it;
    logic [NB-1:0] inv;
    logic          prev_done = 1'b0;
    forever begin
      @(negedge prog_clk);
      if (config_done === 1'b1 && prev_done !== 1'b1) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got config_done=1, expected no commit pending");
        end else begin
          it  = sbq.pop_front();
          inv = ~it.mem;
          chk("mem_out_commit", 32'(mem_out), 32'(it.mem));
          chk("mem_outb_commit", 32'(mem_outb), 32'(inv));
          chk("tail_at_done", 32'(ccff_tail), 32'(it.tail));
          chk("done_latency", 32'(cyc), 32'(it.done_cyc));
`ifdef CONFIG_PARITY_EN
          chk("err_parity_done", 32'(err_parity), 32'(it.err));
`endif
          shown = it.mem;
        end
      end else begin
        inv = ~shown;
        chk("mem_out_hold", 32'(mem_out), 32'(shown));
        chk("mem_outb_hold", 32'(mem_outb), 32'(inv));
      end
      prev_done = config_done;
    end
  end

  initial begin : tail_watch
    forever begin
      @(acc0_ev);
      for (int j = 0; j < NB; j++) begin
        chk("ccff_tail_shift", 32'(ccff_tail), 32'(tail_old[NB-1-j]));
        @(posedge prog_clk);
        #1;
      end
    end
  end

  task automatic do_reset(input int n);
    pReset = 1'b1;
    cfg_valid = 1'b0;
    start = 1'b0;
    @(posedge prog_clk);
    #1;
    shown = '0;
    model_mem = '0;
    model_shadow = '0;
    sbq.delete();
    repeat (n - 1) @(posedge prog_clk);
    #1;
    pReset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge prog_clk);
    #1;
    start = 1'b0;
    chk("done_after_start", 32'(config_done), 32'd0);
    chk("ready_after_start", 32'(cfg_ready), 32'd1);
`ifdef CONFIG_PARITY_EN
    chk("err_cleared_by_start", 32'(err_parity), 32'd0);
`endif
  endtask

  task automatic wait_ready();
    int n = 0;
    while (1) begin
      @(negedge prog_clk);
      if (cfg_ready === 1'b1) break;
      n++;
      if (n > 100) begin
        $display("FAIL handshake_timeout: got cfg_ready=0 for 100 cycles, expected 1");
        $fatal(1);
      end
    end
  endtask

  task automatic run_load(input bit watch);
    int            first = 0;
    int            gsum = 0;
    int            n = 0;
    bit            anybad = 0;
    logic [NB-1:0] sv;
    exp_t          it;
    pulse_start();
    for (int i = 0; i < NW; i++) begin
      if (i > 0 && gq[i] > 0) begin
        cfg_valid = 1'b0;
        gsum += gq[i];
        repeat (WW - 1 + gq[i]) @(posedge prog_clk);
        #1;
      end
      cfg_data = wq[i];
`ifdef CONFIG_PARITY_EN
      cfg_parity = (^wq[i]) ^ bq[i];
      anybad |= bq[i];
`endif
      cfg_valid = 1'b1;
      wait_ready();
      @(posedge prog_clk);
      #1;
      if (i == 0) begin
        first = cyc;
        if (watch) begin
          tail_old = model_shadow;
          ->acc0_ev;
        end
      end
    end
    cfg_valid = 1'b0;
    sv = stream_val();
    it.mem = anybad ? model_mem : sv;
    it.tail = sv[NB-1];
    it.err = anybad;
    it.done_cyc = first + NB + 1 + gsum;
    sbq.push_back(it);
    model_mem = it.mem;
    model_shadow = sv;
    while (config_done !== 1'b1) begin
      @(negedge prog_clk);
      n++;
      if (n > 100) begin
        $display("FAIL done_timeout: got config_done=0 for 100 cycles, expected 1");
        $fatal(1);
      end
    end
    @(posedge prog_clk);
    #1;
  endtask

  task automatic set_load(input logic [WW-1:0] w0, input logic [WW-1:0] w1, input int g, input bit bad1);
    wq[0] = w0; wq[1] = w1;
    gq[0] = 0;  gq[1] = g;
    bq[0] = 0;  bq[1] = bad1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    bit nogap;
    do_reset(2);
    chk("reset_mem_out", 32'(mem_out), 32'h000);
    chk("reset_mem_outb", 32'(mem_outb), 32'hFFF);
    chk("reset_ready", 32'(cfg_ready), 32'd0);
    chk("reset_done", 32'(config_done), 32'd0);
    chk("reset_tail", 32'(ccff_tail), 32'd0);

    set_load(8'hA5, 8'h3C, 0, 0);
    run_load(1);

    do_reset(1);
    set_load(8'hA5, 8'h3C, 5, 0);
    run_load(0);

    set_load(8'hFF, 8'h0F, 0, 0);
    run_load(1);

    // Abort after five shifts; the chain must come back cleared.
    pulse_start();
    cfg_data = 8'hA5;
`ifdef CONFIG_PARITY_EN
    cfg_parity = ^cfg_data;
`endif
    cfg_valid = 1'b1;
    wait_ready();
    @(posedge prog_clk);
    #1;
    cfg_valid = 1'b0;
    repeat (5) @(posedge prog_clk);
    #1;
    do_reset(1);
    chk("midrst_mem_out", 32'(mem_out), 32'h000);
    chk("midrst_mem_outb", 32'(mem_outb), 32'hFFF);
    chk("midrst_ready", 32'(cfg_ready), 32'd0);
    chk("midrst_done", 32'(config_done), 32'd0);
    chk("midrst_tail", 32'(ccff_tail), 32'd0);
    set_load(8'hA5, 8'h3C, 0, 0);
    run_load(1);

`ifdef CONFIG_PARITY_EN
    set_load(8'hFF, 8'h0F, 0, 1);
    run_load(1);
`endif

    for (int r = 0; r < 10; r++) begin
      nogap = 1;
      for (int i = 0; i < NW; i++) begin
        wq[i] = WW'($urandom);
        gq[i] = (i == 0) ? 0 : int'($urandom_range(0, 3));
        bq[i] = 0;
`ifdef CONFIG_PARITY_EN
        bq[i] = ($urandom_range(0, 3) == 0);
`endif
        if (gq[i] != 0) nogap = 0;
      end
      run_load(nogap);
    end

    repeat (3) @(posedge prog_clk);
    #1;
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/config_chain_loader.md
Name: config_chain_loader

Overview:
- Configuration-memory front end for the routing and LUT fabric.
- Accepts bitstream words over a valid/ready handshake and serializes them into a shadow shift chain.
- Once the full chain is loaded, commits it in a single cycle to the mem_out/mem_outb registers, which drive the sel/selb pins of the TGATE pass-gate muxes directly downstream.
- Because the shadow chain is separate from the committed outputs, pass gates never see partial or glitching configuration while a load is in progress.

Parameters:
- NUM_BITS, 32, number of configuration bits in the chain (>=1).
- WORD_W, 8, width of the bitstream word input (>=1).

Ports:
- prog_clk  input  1  programming clock; all state is updated on its rising edge.
- pReset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- cfg_data  input  WORD_W  bitstream word, shifted in LSB first.
- cfg_valid  input  1  cfg_data is valid.
- cfg_ready  output  1  block accepts cfg_data this cycle.
- mem_out  output  NUM_BITS  committed configuration, drives TGATE sel.
- mem_outb  output  NUM_BITS  bitwise complement of mem_out, drives TGATE selb.
- ccff_tail  output  1  serial output, equal to shadow[NUM_BITS-1], for cascading to the next tile.
- config_done  output  1  high while in DONE.
- err_parity  output  1  present only with CONFIG_PARITY_EN.

Behaviour:
- Clock and reset: one clock, prog_clk. pReset is synchronous and active-high.
- Reset values:
  - state = IDLE; shadow = 0; mem_out = 0; mem_outb = all ones.
  - cfg_ready = 0; config_done = 0; ccff_tail = 0; err_parity = 0.
  - Serializer and both counters are cleared.
- Reset mid-load aborts the load immediately and applies the reset values. No commit occurs.
- States: IDLE, SHIFT, COMMIT, DONE.
- IDLE / DONE + start -> SHIFT. On this transition:
  - bit counter and accepted-bit counter are cleared;
  - err_parity is cleared;
  - mem_out holds its old value.
- start is ignored in SHIFT and COMMIT.
- Handshake: a transfer occurs on an edge where cfg_valid && cfg_ready.
  - cfg_ready = (state==SHIFT) && (serializer empty || serializer on its last bit) && (accepted bits < NUM_BITS).
  - cfg_data must stay stable while cfg_valid is high and cfg_ready is low.
- Serialization:
  - A word accepted at edge E shifts bit i at edge E+1+i.
  - Shift operation: shadow <= {shadow[NUM_BITS-2:0], bit}.
  - Stream bit k (counted from 0, first bit first) finishes at mem_out[NUM_BITS-1-k].
  - Back-to-back words incur no bubble: the next word loads on the same edge the previous word's last bit shifts.
- Partial final word: if NUM_BITS % WORD_W != 0, only the low NUM_BITS % WORD_W bits of the last word are shifted; the upper bits are discarded.
- Bubbles: if cfg_valid drops, shifting pauses once the serializer empties. The shadow chain holds.
- End of shift: on the edge that shifts bit NUM_BITS-1, state -> COMMIT.
- COMMIT lasts one cycle. On the next edge:
  - mem_out <= shadow; mem_outb <= ~shadow;
  - state -> DONE; config_done = 1 from that edge onward.
- DONE holds until start or pReset.
- Total latency: NUM_BITS+1 edges from the first accept edge to config_done, assuming no bubbles.
- ccff_tail updates with every shift. It is otherwise static.

Optional Feature:
- Macro: CONFIG_PARITY_EN.
- When defined:
  - adds input cfg_parity (1 bit), checked as even parity over the full cfg_data word at each accept;
  - a mismatch sets err_parity, which is sticky until start or pReset;
  - if err_parity is set when COMMIT is reached, the commit is suppressed: mem_out/mem_outb are unchanged, state still moves to DONE and config_done = 1.
- When undefined:
  - neither cfg_parity nor err_parity exists;
  - commit is unconditional.

Test Plan (NUM_BITS=12, WORD_W=8):
- Reset: assert pReset for 2 cycles -> mem_out=0x000, mem_outb=0xFFF, cfg_ready=0, config_done=0.
- Nominal load: start, then back-to-back words 0xA5 and 0x3C (upper nibble discarded) -> cfg_ready high at accept edges E0 and E8, mem_out=0xA53, mem_outb=0x5AC, config_done high after E13.
- Bubble: same data, cfg_valid low for 5 cycles between words -> same final mem_out=0xA53. mem_out stays at 0x000 throughout shifting. config_done is delayed by 5 cycles.
- Reload from DONE: start, then 0xFF, 0x0F -> mem_out holds 0xA53 until the commit edge, then becomes 0xFFF. ccff_tail shows the old chain bits 1,0,1,0,0,1,0,1,0,0,1,1 over the 12 shifts.
- Reset mid-load: pReset after 5 shifts -> state IDLE, mem_out=0x000, shadow=0. A following start and full load completes normally.
- CONFIG_PARITY_EN: second word sent with wrong parity -> err_parity=1, config_done=1, mem_out unchanged from its previous value. A following start clears err_parity.
